// File: rtl/wind_light_bank.sv
// Runway wind-direction light bank: N lights, four patterns, prescaled step.
// Optional HAZARD mode compiled in with `define WIND_HAZARD_EN.
module wind_light_bank #(
   parameter int N        = 8,
   parameter int TICK_DIV = 25_000_000
) (
   input  logic         CLOCK_50,
   input  logic         reset_n,
   input  logic [1:0]   SW,
   input  logic         hold,
   output logic [N-1:0] LEDR,
   output logic         step
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   function automatic logic [N-1:0] odd_mask();
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) m[i] = i[0];
      return m;
   endfunction

   localparam logic [N-1:0] ODD    = odd_mask();
   localparam logic [N-1:0] ALL    = '1;
   localparam logic [N-1:0] BIT_LO = N'(1);
   localparam logic [N-1:0] BIT_HI = {1'b1, {(N-1){1'b0}}};
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

`ifdef WIND_HAZARD_EN
   typedef enum logic [1:0] {CALM, SWEEP_L, SWEEP_R, HAZARD} state_t;
`else
   typedef enum logic [1:0] {CALM, SWEEP_L, SWEEP_R} state_t;
`endif

   state_t         state, nxt_state, sw_mode;
   logic [N-1:0]   pat, nxt_pat;
   logic [CW-1:0]  cnt;
   logic           step_edge;
   logic           sweeping;

   assign step_edge = !hold && (cnt == CNT_LAST);
   assign sweeping  = (state == SWEEP_L) || (state == SWEEP_R);
   assign LEDR      = pat;

   // Without the hazard build, SW=11 collapses onto the right sweep.
   always_comb begin
      sw_mode = CALM;
      case (SW)
         2'b00:   sw_mode = CALM;
         2'b01:   sw_mode = SWEEP_L;
         2'b10:   sw_mode = SWEEP_R;
`ifdef WIND_HAZARD_EN
         default: sw_mode = HAZARD;
`else
         default: sw_mode = SWEEP_R;
`endif
      endcase
   end

   // Reversal keeps the lit index and moves one place in the new direction.
   always_comb begin
      nxt_state = sw_mode;
      nxt_pat   = pat;
      case (sw_mode)
         CALM:    nxt_pat = (state == CALM) ? ~pat : ODD;
         SWEEP_L: nxt_pat = sweeping ? {pat[N-2:0], pat[N-1]} : BIT_LO;
         SWEEP_R: nxt_pat = sweeping ? {pat[0], pat[N-1:1]} : BIT_HI;
`ifdef WIND_HAZARD_EN
         HAZARD:  nxt_pat = (state == HAZARD) ? ~pat : ALL;
`endif
         default: nxt_pat = ODD;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!hold) begin
         cnt <= step_edge ? '0 : cnt + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state <= CALM;
         pat   <= ODD;
         step  <= 1'b0;
      end else begin
         step <= step_edge;
         if (step_edge) begin
            state <= nxt_state;
            pat   <= nxt_pat;
         end
      end
   end

endmodule

// File: tb/tb_wind_light_bank.sv
// Directed bench for wind_light_bank: N=4/TICK_DIV=3 main instance, N=3/TICK_DIV=1 side instance.
module tb_wind_light_bank;

   logic       CLOCK_50 = 1'b0;
   logic       reset_n  = 1'b0;
   logic [1:0] SW       = 2'b00;
   logic       hold     = 1'b0;
   logic [3:0] LEDR;
   logic       step;
   logic [2:0] LEDR1;
   logic       step1;

   int errors = 0;
   int checks = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   wind_light_bank #(.N(4), .TICK_DIV(3)) dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .SW(SW), .hold(hold),
      .LEDR(LEDR), .step(step)
   );

   wind_light_bank #(.N(3), .TICK_DIV(1)) dut1 (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .SW(SW), .hold(hold),
      .LEDR(LEDR1), .step(step1)
   );

   // Advance edges until step is seen (bounded); n = edges taken.
   task automatic edges_to_step(output int n);
      n = 0;
      do begin
         @(posedge CLOCK_50); #1;
         n++;
      end while (step !== 1'b1 && n < 20);
   endtask

   task automatic test_tick1;
      logic [2:0] exp;
      reset_n = 1'b0; SW = 2'b00; hold = 1'b0;
      #12;
      checks++;
      if (LEDR1 !== 3'b010 || step1 !== 1'b0) begin
         errors++; $display("FAIL tick1_reset: LEDR=%b step=%b want 010/0", LEDR1, step1);
      end
      @(negedge CLOCK_50); reset_n = 1'b1;
      exp = 3'b010;
      for (int k = 0; k < 4; k++) begin
         @(posedge CLOCK_50); #1;
         exp = ~exp;
         checks++;
         if (LEDR1 !== exp || step1 !== 1'b1) begin
            errors++; $display("FAIL tick1_edge%0d: LEDR=%b step=%b want %b/1", k, LEDR1, step1, exp);
         end
      end
   endtask

   task automatic test_reset;
      @(negedge CLOCK_50); reset_n = 1'b0; SW = 2'b00;
      #2;
      checks++;
      if (LEDR !== 4'b1010 || step !== 1'b0) begin
         errors++; $display("FAIL reset: LEDR=%b step=%b want 1010/0", LEDR, step);
      end
      @(negedge CLOCK_50); reset_n = 1'b1;
   endtask

   task automatic test_calm;
      logic [3:0] exp [3] = '{4'b0101, 4'b1010, 4'b0101};
      for (int k = 0; k < 3; k++) begin
         for (int e = 0; e < 2; e++) begin
            @(posedge CLOCK_50); #1;
            checks++;
            if (step !== 1'b0) begin
               errors++; $display("FAIL calm_nostep%0d_%0d: step=%b want 0", k, e, step);
            end
         end
         @(posedge CLOCK_50); #1;
         checks++;
         if (step !== 1'b1 || LEDR !== exp[k]) begin
            errors++; $display("FAIL calm_step%0d: LEDR=%b step=%b want %b/1", k, LEDR, step, exp[k]);
         end
      end
   endtask

   task automatic test_glitch;
      int n;
      @(posedge CLOCK_50); #1; SW = 2'b01;
      @(posedge CLOCK_50); #1; SW = 2'b00;
      @(posedge CLOCK_50); #1;
      checks++;
      if (step !== 1'b1 || LEDR !== 4'b1010) begin
         errors++; $display("FAIL glitch: LEDR=%b step=%b want 1010/1", LEDR, step);
      end
      n = 0;
   endtask

   task automatic test_sweep_left;
      logic [3:0] exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      int n;
      SW = 2'b01;
      for (int k = 0; k < 7; k++) begin
         edges_to_step(n);
         checks++;
         if (n != 3 || LEDR !== exp[k]) begin
            errors++; $display("FAIL sweepl%0d: LEDR=%b edges=%0d want %b/3", k, LEDR, n, exp[k]);
         end
      end
   endtask

   task automatic test_reversal;
      logic [3:0] exp [4] = '{4'b0010, 4'b0001, 4'b1000, 4'b1010};
      int n;
      SW = 2'b10;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) SW = 2'b00;
         edges_to_step(n);
         checks++;
         if (n != 3 || LEDR !== exp[k]) begin
            errors++; $display("FAIL reversal%0d: LEDR=%b edges=%0d want %b/3", k, LEDR, n, exp[k]);
         end
      end
   endtask

   task automatic test_hazard;
`ifdef WIND_HAZARD_EN
      logic [3:0] exp [4] = '{4'b1111, 4'b0000, 4'b1111, 4'b1010};
`else
      logic [3:0] exp [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b1010};
`endif
      int n;
      SW = 2'b11;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) SW = 2'b00;
         edges_to_step(n);
         checks++;
         if (n != 3 || LEDR !== exp[k]) begin
            errors++; $display("FAIL hazard%0d: LEDR=%b edges=%0d want %b/3", k, LEDR, n, exp[k]);
         end
      end
   endtask

   task automatic test_hold;
      int n;
      @(posedge CLOCK_50); #1;
      hold = 1'b1;
      for (int e = 0; e < 10; e++) begin
         @(posedge CLOCK_50); #1;
         checks++;
         if (LEDR !== 4'b1010 || step !== 1'b0) begin
            errors++; $display("FAIL hold%0d: LEDR=%b step=%b want 1010/0", e, LEDR, step);
         end
      end
      hold = 1'b0;
      edges_to_step(n);
      checks++;
      if (n != 2 || LEDR !== 4'b0101) begin
         errors++; $display("FAIL hold_resume: LEDR=%b edges=%0d want 0101/2", LEDR, n);
      end
   endtask

   task automatic test_async_reset;
      logic [3:0] exp [3] = '{4'b0001, 4'b0010, 4'b0100};
      int n;
      SW = 2'b01;
      for (int k = 0; k < 3; k++) begin
         edges_to_step(n);
         checks++;
         if (n != 3 || LEDR !== exp[k]) begin
            errors++; $display("FAIL areset_pre%0d: LEDR=%b edges=%0d want %b/3", k, LEDR, n, exp[k]);
         end
      end
      #2; reset_n = 1'b0;
      #1;
      checks++;
      if (LEDR !== 4'b1010 || step !== 1'b0) begin
         errors++; $display("FAIL areset: LEDR=%b step=%b want 1010/0", LEDR, step);
      end
      @(negedge CLOCK_50); reset_n = 1'b1;
      edges_to_step(n);
      checks++;
      if (n != 3 || LEDR !== 4'b0001) begin
         errors++; $display("FAIL areset_post: LEDR=%b edges=%0d want 0001/3", LEDR, n);
      end
   endtask

   initial begin
      test_tick1;
      test_reset;
      test_calm;
      test_glitch;
      test_sweep_left;
      test_reversal;
      test_hazard;
      test_hold;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
